// File: rtl/enc_rr_arbiter.sv
// ---------------------------------------------------------------------------
// enc_rr_arbiter
//   Round-robin arbiter that sequences up to N users of the shared 8-to-3
//   encoder datapath. The winner is presented both one-hot (gnt) and binary
//   encoded (gnt_idx), with bit k mapping to index k like the team encoder.
//   An owner keeps the grant while its request stays high. When others are
//   waiting, it keeps the grant for at most MAX_HOLD consecutive cycles.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      asynchronous, active-high reset
//   en       in   1      arbiter enable; low forces release of any grant
//   req      in   N      request vector, bit k = requester k
//   gnt      out  N      registered one-hot grant (or zero)
//   gnt_idx  out  IDX_W  binary index of the granted requester (0 when idle)
//   gnt_vld  out  1      high while gnt is non-zero
// ---------------------------------------------------------------------------
module enc_rr_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(MAX_HOLD);
  localparam logic [HC_W-1:0]  HOLD_ONE = HC_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // What the output process must do with the grant registers on this edge.
  typedef enum logic [1:0] {
    ACT_CLEAR = 2'd0,  // drop any grant, outputs to zero
    ACT_NEW   = 2'd1,  // grant the search winner starting at ptr_nxt_s
    ACT_KEEP  = 2'd2   // keep current owner, advance hold counter (saturating)
  } act_t;

  // Round-robin search: first set bit at or after 'start', wrapping mod N.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0]     r,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] pick;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = start + IDX_W'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

  // Index to one-hot decode, same bit-to-index mapping as the encoder.
  function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  act_t             act_s;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] ptr_nxt_s;
  logic [HC_W-1:0]  hold_cnt_r;
  logic [HC_W-1:0]  hold_cnt_nxt_s;
  logic [N-1:0]     gnt_r;
  logic [N-1:0]     gnt_nxt_s;
  logic [IDX_W-1:0] gnt_idx_r;
  logic [IDX_W-1:0] gnt_idx_nxt_s;
  logic             gnt_vld_r;
  logic             gnt_vld_nxt_s;

  logic             req_any_s;
  logic             owner_req_s;
  logic             others_s;
  logic [IDX_W-1:0] owner_nxt_s;
  logic [IDX_W-1:0] pick_s;

  assign req_any_s   = |req;
  assign owner_req_s = req[gnt_idx_r];
  // gnt_r is one-hot on the owner, so masking it leaves only waiting requesters.
  assign others_s    = |(req & ~gnt_r);
  assign owner_nxt_s = gnt_idx_r + IDX_ONE;
  assign pick_s      = rr_pick(req, ptr_nxt_s);

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      ptr_r      <= '0;
      hold_cnt_r <= '0;
      gnt_r      <= '0;
      gnt_idx_r  <= '0;
      gnt_vld_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ptr_r      <= ptr_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      gnt_r      <= gnt_nxt_s;
      gnt_idx_r  <= gnt_idx_nxt_s;
      gnt_vld_r  <= gnt_vld_nxt_s;
    end
  end

  // Next-state decision: state, search pointer and grant action.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    act_s       = ACT_CLEAR;
    case (state_r)
      ST_IDLE: begin
        if (en && req_any_s) begin
          state_nxt_s = ST_GRANT;
          act_s       = ACT_NEW;
        end else begin
          state_nxt_s = ST_IDLE;
          act_s       = ACT_CLEAR;
        end
      end
      ST_GRANT: begin
        if (!en) begin
          // Forced release; the pointer is deliberately left where it was.
          state_nxt_s = ST_IDLE;
          act_s       = ACT_CLEAR;
        end else if (!owner_req_s) begin
          // Owner released: next search starts just past it, back-to-back if possible.
          ptr_nxt_s = owner_nxt_s;
          if (req_any_s) begin
            state_nxt_s = ST_GRANT;
            act_s       = ACT_NEW;
          end else begin
            state_nxt_s = ST_IDLE;
            act_s       = ACT_CLEAR;
          end
        end else if ((hold_cnt_r == HOLD_MAX) && others_s) begin
          // Forced rotation. Another bit is set, so the search from owner+1
          // hits it before wrapping back to the owner.
          ptr_nxt_s   = owner_nxt_s;
          state_nxt_s = ST_GRANT;
          act_s       = ACT_NEW;
        end else begin
          state_nxt_s = ST_GRANT;
          act_s       = ACT_KEEP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        ptr_nxt_s   = '0;
        act_s       = ACT_CLEAR;
      end
    endcase
  end

  // Next values of the registered grant outputs and hold counter.
  always_comb begin
    gnt_nxt_s      = '0;
    gnt_idx_nxt_s  = '0;
    gnt_vld_nxt_s  = 1'b0;
    hold_cnt_nxt_s = '0;
    case (act_s)
      ACT_CLEAR: begin
        gnt_nxt_s      = '0;
        gnt_idx_nxt_s  = '0;
        gnt_vld_nxt_s  = 1'b0;
        hold_cnt_nxt_s = '0;
      end
      ACT_NEW: begin
        gnt_nxt_s      = to_onehot(pick_s);
        gnt_idx_nxt_s  = pick_s;
        gnt_vld_nxt_s  = 1'b1;
        hold_cnt_nxt_s = HOLD_ONE;
      end
      ACT_KEEP: begin
        gnt_nxt_s     = gnt_r;
        gnt_idx_nxt_s = gnt_idx_r;
        gnt_vld_nxt_s = gnt_vld_r;
        if (hold_cnt_r < HOLD_MAX) begin
          hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
        end else begin
          hold_cnt_nxt_s = HOLD_MAX;
        end
      end
      default: begin
        gnt_nxt_s      = '0;
        gnt_idx_nxt_s  = '0;
        gnt_vld_nxt_s  = 1'b0;
        hold_cnt_nxt_s = '0;
      end
    endcase
  end

  assign gnt     = gnt_r;
  assign gnt_idx = gnt_idx_r;
  assign gnt_vld = gnt_vld_r;

endmodule
